// File: rtl/decode_stage_pipe.sv
// RV32I decoder registered as the ID/EX pipeline stage.
// Valid/ready output register with a one-bubble load-use stall, flush and illegal-instruction flagging.
module decode_stage_pipe #(
    parameter int ADDRR_BITS = 16,
    parameter int CNT_BITS   = 16,
    parameter int ALU_W      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [31:0]           instr_i,
    input  logic [ADDRR_BITS-1:0] pc_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [4:0]            rd_o,
    output logic [4:0]            rs1_o,
    output logic [4:0]            rs2_o,
    output logic                  reg_write_en_o,
    output logic                  mem_write_en_o,
    output logic                  mem_read_en_o,
    output logic                  op_b_sel_o,
    output logic                  data_to_reg_o,
    output logic [ALU_W-1:0]      alu_cntrl_o,
    output logic [2:0]            br_func_o,
    output logic                  is_branch_o,
    output logic                  is_jump_o,
    output logic [31:0]           imm_o,
    output logic [ADDRR_BITS-1:0] target_pc_o,
    output logic [ADDRR_BITS-1:0] pc_out_o,
    output logic                  illegal_o,
    output logic [CNT_BITS-1:0]   decoded_count_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [ALU_W-1:0] ALU_ADD   = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_SUB   = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_AND   = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_OR    = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_XOR   = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALU_SLT   = ALU_W'(5);
    localparam logic [ALU_W-1:0] ALU_SLTU  = ALU_W'(6);
    localparam logic [ALU_W-1:0] ALU_SLL   = ALU_W'(7);
    localparam logic [ALU_W-1:0] ALU_SRL   = ALU_W'(8);
    localparam logic [ALU_W-1:0] ALU_SRA   = ALU_W'(9);
    localparam logic [ALU_W-1:0] ALU_PASSB = ALU_W'(10);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_in, rs1_in, rs2_in;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rd_in  = instr_i[11:7];
    assign rs1_in = instr_i[19:15];
    assign rs2_in = instr_i[24:20];

    logic [31:0] imm_i_w, imm_s_w, imm_b_w, imm_u_w, imm_j_w;

    assign imm_i_w = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s_w = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b_w = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u_w = {instr_i[31:12], 12'b0};
    assign imm_j_w = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    logic                  reg_write_en_d, mem_write_en_d, mem_read_en_d;
    logic                  op_b_sel_d, data_to_reg_d, is_branch_d, is_jump_d, illegal_d;
    logic [ALU_W-1:0]      alu_cntrl_d;
    logic [31:0]           imm_d;
    logic [ADDRR_BITS-1:0] target_pc_d;

    always_comb begin
        reg_write_en_d = 1'b0;
        mem_write_en_d = 1'b0;
        mem_read_en_d  = 1'b0;
        op_b_sel_d     = 1'b0;
        data_to_reg_d  = 1'b0;
        is_branch_d    = 1'b0;
        is_jump_d      = 1'b0;
        illegal_d      = 1'b0;
        alu_cntrl_d    = ALU_ADD;
        imm_d          = 32'd0;
        target_pc_d    = '0;
        unique case (opcode)
            OP_R: begin
                reg_write_en_d = 1'b1;
                illegal_d = !((funct7 == F7_ZERO) ||
                              ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
                case (funct3)
                    3'b000:  alu_cntrl_d = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_cntrl_d = ALU_SLL;
                    3'b010:  alu_cntrl_d = ALU_SLT;
                    3'b011:  alu_cntrl_d = ALU_SLTU;
                    3'b100:  alu_cntrl_d = ALU_XOR;
                    3'b101:  alu_cntrl_d = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_cntrl_d = ALU_OR;
                    default: alu_cntrl_d = ALU_AND;
                endcase
            end
            OP_I: begin
                reg_write_en_d = 1'b1;
                op_b_sel_d     = 1'b1;
                imm_d          = imm_i_w;
                case (funct3)
                    3'b000:  alu_cntrl_d = ALU_ADD;
                    3'b001: begin
                        alu_cntrl_d = ALU_SLL;
                        illegal_d   = (funct7 != F7_ZERO);
                    end
                    3'b010:  alu_cntrl_d = ALU_SLT;
                    3'b011:  alu_cntrl_d = ALU_SLTU;
                    3'b100:  alu_cntrl_d = ALU_XOR;
                    3'b101: begin
                        alu_cntrl_d = funct7[5] ? ALU_SRA : ALU_SRL;
                        illegal_d   = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
                    end
                    3'b110:  alu_cntrl_d = ALU_OR;
                    default: alu_cntrl_d = ALU_AND;
                endcase
            end
            OP_LOAD: begin
                reg_write_en_d = 1'b1;
                op_b_sel_d     = 1'b1;
                mem_read_en_d  = 1'b1;
                data_to_reg_d  = 1'b1;
                imm_d          = imm_i_w;
            end
            OP_STORE: begin
                mem_write_en_d = 1'b1;
                op_b_sel_d     = 1'b1;
                imm_d          = imm_s_w;
            end
            OP_BRANCH: begin
                is_branch_d = 1'b1;
                imm_d       = imm_b_w;
                target_pc_d = pc_i + imm_b_w[ADDRR_BITS-1:0];
                case (funct3)
                    3'b000, 3'b001: alu_cntrl_d = ALU_SUB;
                    3'b100, 3'b101: alu_cntrl_d = ALU_SLT;
                    3'b110, 3'b111: alu_cntrl_d = ALU_SLTU;
                    default:        illegal_d   = 1'b1;
                endcase
            end
            OP_LUI: begin
                reg_write_en_d = 1'b1;
                op_b_sel_d     = 1'b1;
                alu_cntrl_d    = ALU_PASSB;
                imm_d          = imm_u_w;
            end
            OP_JAL: begin
                reg_write_en_d = 1'b1;
                is_jump_d      = 1'b1;
                imm_d          = imm_j_w;
                target_pc_d    = pc_i + imm_j_w[ADDRR_BITS-1:0];
            end
            OP_JALR: begin
                reg_write_en_d = 1'b1;
                is_jump_d      = 1'b1;
                op_b_sel_d     = 1'b1;
                imm_d          = imm_i_w;
            end
            default: illegal_d = 1'b1;
        endcase
        if (illegal_d) begin
            reg_write_en_d = 1'b0;
            mem_write_en_d = 1'b0;
            mem_read_en_d  = 1'b0;
            is_branch_d    = 1'b0;
            is_jump_d      = 1'b0;
        end
        if (rd_in == 5'd0) reg_write_en_d = 1'b0;
    end

    logic                  out_valid_q, reg_write_en_q, mem_write_en_q, mem_read_en_q;
    logic                  op_b_sel_q, data_to_reg_q, is_branch_q, is_jump_q, illegal_q;
    logic [4:0]            rd_q, rs1_q, rs2_q;
    logic [ALU_W-1:0]      alu_cntrl_q;
    logic [2:0]            br_func_q;
    logic [31:0]           imm_q;
    logic [ADDRR_BITS-1:0] target_pc_q, pc_q;
    logic [CNT_BITS-1:0]   cnt_q;

    logic uses_rs1, uses_rs2, hazard, adv, accept;

    assign uses_rs1 = (opcode != OP_LUI) && (opcode != OP_JAL);
    assign uses_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    // The load in the output register cannot forward its data until it has left this stage.
    assign hazard   = out_valid_q && mem_read_en_q && (rd_q != 5'd0) &&
                      ((uses_rs1 && (rs1_in == rd_q)) || (uses_rs2 && (rs2_in == rd_q)));
    assign adv        = !out_valid_q || out_ready_i;
    assign in_ready_o = adv && !hazard && !flush_i && !rst_i;
    assign accept     = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q    <= 1'b0;
            rd_q           <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            reg_write_en_q <= 1'b0;
            mem_write_en_q <= 1'b0;
            mem_read_en_q  <= 1'b0;
            op_b_sel_q     <= 1'b0;
            data_to_reg_q  <= 1'b0;
            alu_cntrl_q    <= '0;
            br_func_q      <= '0;
            is_branch_q    <= 1'b0;
            is_jump_q      <= 1'b0;
            imm_q          <= '0;
            target_pc_q    <= '0;
            pc_q           <= '0;
            illegal_q      <= 1'b0;
            cnt_q          <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (adv) begin
            out_valid_q <= accept;
            if (accept) begin
                rd_q           <= rd_in;
                rs1_q          <= rs1_in;
                rs2_q          <= rs2_in;
                reg_write_en_q <= reg_write_en_d;
                mem_write_en_q <= mem_write_en_d;
                mem_read_en_q  <= mem_read_en_d;
                op_b_sel_q     <= op_b_sel_d;
                data_to_reg_q  <= data_to_reg_d;
                alu_cntrl_q    <= alu_cntrl_d;
                br_func_q      <= funct3;
                is_branch_q    <= is_branch_d;
                is_jump_q      <= is_jump_d;
                imm_q          <= imm_d;
                target_pc_q    <= target_pc_d;
                pc_q           <= pc_i;
                illegal_q      <= illegal_d;
                cnt_q          <= cnt_q + CNT_BITS'(1);
            end
        end
    end

    assign out_valid_o     = out_valid_q;
    assign rd_o            = rd_q;
    assign rs1_o           = rs1_q;
    assign rs2_o           = rs2_q;
    assign reg_write_en_o  = reg_write_en_q;
    assign mem_write_en_o  = mem_write_en_q;
    assign mem_read_en_o   = mem_read_en_q;
    assign op_b_sel_o      = op_b_sel_q;
    assign data_to_reg_o   = data_to_reg_q;
    assign alu_cntrl_o     = alu_cntrl_q;
    assign br_func_o       = br_func_q;
    assign is_branch_o     = is_branch_q;
    assign is_jump_o       = is_jump_q;
    assign imm_o           = imm_q;
    assign target_pc_o     = target_pc_q;
    assign pc_out_o        = pc_q;
    assign illegal_o       = illegal_q;
    assign decoded_count_o = cnt_q;

endmodule
